// File: rtl/light_show_seq_if.sv
// Pattern-control and display bundle for light_show_seq.
// The master side drives the switches and observes the pins; the slave side is the sequencer.
`timescale 1ns/1ps
interface light_show_seq_if #(
  parameter int NUM_DIGITS = 4
);
  logic [1:0]            mode;
  logic [1:0]            rate_sel;
  logic                  run;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] dig;
  logic [7:0]            led;
  logic                  step_pulse;

  modport master (output mode, rate_sel, run, input seg, dig, led, step_pulse);
  modport slave  (input mode, rate_sel, run, output seg, dig, led, step_pulse);
endinterface

// File: rtl/light_show_seq.sv
// Light-show sequencer: chase / knight-rider / blink patterns on a multiplexed 7-segment bank and 8 LEDs.
// Optional LIGHT_SHOW_DP_HEARTBEAT_EN: digit 0's DP toggles on every pattern step.
`timescale 1ns/1ps
module light_show_seq #(
  parameter int NUM_DIGITS  = 4,
  parameter int STEP_DIV0   = 50_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic            clk_100mhz,
  input  logic            rst_n,
  light_show_seq_if.slave bus
);
  localparam int PW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int CW = (STEP_DIV0   > 1) ? $clog2(STEP_DIV0)   : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST_POS = PW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] LAST_REF = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {MODE_OFF, MODE_CHASE, MODE_KNIGHT, MODE_BLINK} mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  mode_e                 mode_q, mode_d;
  dir_e                  dir_q, dir_d;
  logic                  primed_q, primed_d;
  logic [CW-1:0]         pcnt_q, pcnt_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [2:0]            sidx_q, sidx_d;
  logic                  tog_q, tog_d;
  logic [PW-1:0]         scan_q, scan_d;
  logic [RW-1:0]         rcnt_q, rcnt_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic [7:0]            led_q, led_d;
  logic                  step_q, step_d;
`ifdef LIGHT_SHOW_DP_HEARTBEAT_EN
  logic                  hb_q, hb_d;
`endif

  logic [31:0] limit;
  logic        term, mode_chg, step;
  logic [7:0]  pat;

  always_comb begin
    primed_d = 1'b1;
    mode_d   = mode_q;
    dir_d    = dir_q;
    pcnt_d   = pcnt_q;
    pos_d    = pos_q;
    sidx_d   = sidx_q;
    tog_d    = tog_q;
    scan_d   = scan_q;
    rcnt_d   = rcnt_q;
`ifdef LIGHT_SHOW_DP_HEARTBEAT_EN
    hb_d     = hb_q;
`endif

    limit = 32'(STEP_DIV0) >> bus.rate_sel;
    if (limit == 32'd0) limit = 32'd1;
    // >= rather than == so a faster rate selected mid-count steps at once
    term = 32'(pcnt_q) >= (limit - 32'd1);

    // The first mode sampled after reset is adopted silently: reset already left the cleared state.
    mode_chg = primed_q && (bus.mode != mode_q);
    step     = bus.run && !mode_chg && term;
    step_d   = step && (mode_q != MODE_OFF);

    if (!primed_q || mode_chg) mode_d = mode_e'(bus.mode);

    if (mode_chg) begin
      pcnt_d = '0;
      pos_d  = '0;
      sidx_d = '0;
      tog_d  = 1'b0;
      dir_d  = DIR_UP;
    end else if (bus.run) begin
      pcnt_d = term ? '0 : pcnt_q + 1'b1;
    end

    if (step_d) begin
`ifdef LIGHT_SHOW_DP_HEARTBEAT_EN
      hb_d = ~hb_q;
`endif
      unique case (mode_q)
        MODE_CHASE: begin
          if (sidx_q == 3'd5) begin
            sidx_d = '0;
            pos_d  = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
          end else begin
            sidx_d = sidx_q + 1'b1;
          end
        end
        MODE_KNIGHT: begin
          if (dir_q == DIR_UP) begin
            if (pos_q == LAST_POS) begin
              pos_d = pos_q - 1'b1;
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = PW'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
        MODE_BLINK: tog_d = ~tog_q;
        default: ;
      endcase
    end

    if (rcnt_q == LAST_REF) begin
      rcnt_d = '0;
      scan_d = (scan_q == LAST_POS) ? '0 : scan_q + 1'b1;
    end else begin
      rcnt_d = rcnt_q + 1'b1;
    end

    pat   = 8'hFF;
    led_d = 8'h00;
    unique case (mode_q)
      MODE_CHASE: begin
        if (scan_q == pos_q) pat = ~(8'b1 << sidx_q);
        led_d = 8'b1 << sidx_q;
      end
      MODE_KNIGHT: begin
        if (scan_q == pos_q) pat = 8'hBF;
        led_d = 8'b1 << pos_q;
      end
      MODE_BLINK: begin
        if (tog_q) begin
          pat   = 8'h80;
          led_d = 8'hFF;
        end
      end
      default: ;
    endcase
`ifdef LIGHT_SHOW_DP_HEARTBEAT_EN
    if (scan_q == '0 && mode_q != MODE_OFF) pat[7] = ~hb_q;
`endif
    seg_d         = pat;
    dig_d         = '1;
    dig_d[scan_q] = 1'b0;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      primed_q <= 1'b0;
      mode_q   <= MODE_OFF;
      dir_q    <= DIR_UP;
      pcnt_q   <= '0;
      pos_q    <= '0;
      sidx_q   <= '0;
      tog_q    <= 1'b0;
      scan_q   <= '0;
      rcnt_q   <= '0;
      seg_q    <= 8'hFF;
      dig_q    <= '1;
      led_q    <= '0;
      step_q   <= 1'b0;
`ifdef LIGHT_SHOW_DP_HEARTBEAT_EN
      hb_q     <= 1'b0;
`endif
    end else begin
      primed_q <= primed_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      pcnt_q   <= pcnt_d;
      pos_q    <= pos_d;
      sidx_q   <= sidx_d;
      tog_q    <= tog_d;
      scan_q   <= scan_d;
      rcnt_q   <= rcnt_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      led_q    <= led_d;
      step_q   <= step_d;
`ifdef LIGHT_SHOW_DP_HEARTBEAT_EN
      hb_q     <= hb_d;
`endif
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig        = dig_q;
  assign bus.led        = led_q;
  assign bus.step_pulse = step_q;
endmodule
